// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, answered a fixed LATENCY cycles after accept.
// Backed by a byte-maskable 64-bit-word array with range checking against BASE_ADDR.
//
// state | meaning
// IDLE  | ready for a request; accept when rwvalid_i && !flush_flag_i
// BUSY  | waiting; counter counts down from LATENCY-1
// RESP  | response cycle; rdata_valid_o / err_o may pulse
module dmem_responder #(
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rwvalid_i,
   input  logic        mem_ren_i,
   input  logic [63:0] mem_raddr_i,
   input  logic        mem_wen_i,
   input  logic [63:0] mem_waddr_i,
   input  logic [63:0] mem_wdata_i,
   input  logic [7:0]  mem_wmask_i,
   input  logic        flush_flag_i,
   output logic        ready_o,
   output logic [63:0] mem_rdata_o,
   output logic        rdata_valid_o,
   output logic        err_o
);

   localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [63:0] LIMIT    = BASE_ADDR + (64'd8 << DEPTH_LOG2);
   localparam int unsigned CW       = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
   localparam bit          DIRECT   = (LATENCY == 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [63:0]           r_mem [DEPTH];

   logic                  r_rd_pend;
   logic                  r_wen;
   logic                  r_rd_ok;
   logic                  r_wr_ok;
   logic                  r_err;
   logic [DEPTH_LOG2-1:0] r_ridx;
   logic [DEPTH_LOG2-1:0] r_widx;
   logic [63:0]           r_wdata;
   logic [7:0]            r_wmask;
   logic [CW-1:0]         r_cnt;
   logic [63:0]           r_rdata;

   logic                  w_accept;
   logic                  w_enter_resp;
   logic                  w_rd_ok_in;
   logic                  w_wr_ok_in;
   logic [DEPTH_LOG2-1:0] w_ridx_in;
   logic [DEPTH_LOG2-1:0] w_widx_in;

   logic                  w_a_ren;
   logic                  w_a_wen;
   logic                  w_a_rok;
   logic                  w_a_wok;
   logic [DEPTH_LOG2-1:0] w_a_ridx;
   logic [DEPTH_LOG2-1:0] w_a_widx;
   logic [63:0]           w_a_wdata;
   logic [7:0]            w_a_wmask;

   // Full 64-bit compare so that addresses far above the window never alias into it.
   assign w_rd_ok_in = (mem_raddr_i >= BASE_ADDR) && (mem_raddr_i < LIMIT);
   assign w_wr_ok_in = (mem_waddr_i >= BASE_ADDR) && (mem_waddr_i < LIMIT);
   assign w_ridx_in  = DEPTH_LOG2'((mem_raddr_i - BASE_ADDR) >> 3);
   assign w_widx_in  = DEPTH_LOG2'((mem_waddr_i - BASE_ADDR) >> 3);

   assign w_accept   = rwvalid_i && (r_state == ST_IDLE) && !flush_flag_i;

   // With LATENCY=1 the array is accessed on the accept edge itself, so the live inputs
   // are used; otherwise the request latched at accept drives the access.
   assign w_a_ren    = (DIRECT ? mem_ren_i   : r_rd_pend) && !flush_flag_i;
   assign w_a_wen    =  DIRECT ? mem_wen_i   : r_wen;
   assign w_a_rok    =  DIRECT ? w_rd_ok_in  : r_rd_ok;
   assign w_a_wok    =  DIRECT ? w_wr_ok_in  : r_wr_ok;
   assign w_a_ridx   =  DIRECT ? w_ridx_in   : r_ridx;
   assign w_a_widx   =  DIRECT ? w_widx_in   : r_widx;
   assign w_a_wdata  =  DIRECT ? mem_wdata_i : r_wdata;
   assign w_a_wmask  =  DIRECT ? mem_wmask_i : r_wmask;

   assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      ready_o       = 1'b0;
      rdata_valid_o = 1'b0;
      err_o         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ready_o = 1'b1;
            if (w_accept) begin
               w_state_nxt = DIRECT ? ST_RESP : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (r_cnt == CW'(1)) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            rdata_valid_o = r_rd_pend && !flush_flag_i;
            err_o         = r_err;
            w_state_nxt   = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_pend <= 1'b0;
         r_wen     <= 1'b0;
         r_rd_ok   <= 1'b0;
         r_wr_ok   <= 1'b0;
         r_err     <= 1'b0;
         r_ridx    <= '0;
         r_widx    <= '0;
         r_wdata   <= '0;
         r_wmask   <= '0;
         r_cnt     <= '0;
         r_rdata   <= '0;
      end else begin
         if (w_accept) begin
            r_wen   <= mem_wen_i;
            r_rd_ok <= w_rd_ok_in;
            r_wr_ok <= w_wr_ok_in;
            r_err   <= (mem_ren_i && !w_rd_ok_in) || (mem_wen_i && !w_wr_ok_in);
            r_ridx  <= w_ridx_in;
            r_widx  <= w_widx_in;
            r_wdata <= mem_wdata_i;
            r_wmask <= mem_wmask_i;
            r_cnt   <= CNT_LOAD;
         end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt - CW'(1);
         end

         if (w_accept) begin
            r_rd_pend <= mem_ren_i;
         end else if ((r_state != ST_IDLE) && flush_flag_i) begin
            r_rd_pend <= 1'b0;
         end

         // Non-blocking read of the array gives read-before-write for ren+wen requests.
         if (w_enter_resp && w_a_ren) begin
            r_rdata <= w_a_rok ? r_mem[w_a_ridx] : 64'h0;
         end
      end
   end

   // A write still in flight when rst arrives never reaches the array.
   always_ff @(posedge clk) begin
      if (!rst && w_enter_resp && w_a_wen && w_a_wok) begin
         for (int i = 0; i < 8; i++) begin
            if (w_a_wmask[i]) begin
               r_mem[w_a_widx][8*i +: 8] <= w_a_wdata[8*i +: 8];
            end
         end
      end
   end

   assign mem_rdata_o = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 2, 5) driven one at a time,
// checked every cycle against a word-level memory model plus a few literal values.
module tb_dmem_responder;

   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam logic [63:0] LIMIT = BASE + 64'd32768;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst     [3];
   logic        rwvalid [3];
   logic        ren     [3];
   logic        wen     [3];
   logic        flush   [3];
   logic [63:0] raddr   [3];
   logic [63:0] waddr   [3];
   logic [63:0] wdata   [3];
   logic [7:0]  wmask   [3];
   logic        ready   [3];
   logic        valid   [3];
   logic        err     [3];
   logic [63:0] rdata   [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
      dmem_responder #(
         .LATENCY   (LAT),
         .DEPTH_LOG2(12),
         .BASE_ADDR (BASE)
      ) u_dut (
         .clk          (clk),
         .rst          (rst[g]),
         .rwvalid_i    (rwvalid[g]),
         .mem_ren_i    (ren[g]),
         .mem_raddr_i  (raddr[g]),
         .mem_wen_i    (wen[g]),
         .mem_waddr_i  (waddr[g]),
         .mem_wdata_i  (wdata[g]),
         .mem_wmask_i  (wmask[g]),
         .flush_flag_i (flush[g]),
         .ready_o      (ready[g]),
         .mem_rdata_o  (rdata[g]),
         .rdata_valid_o(valid[g]),
         .err_o        (err[g])
      );
   end

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          run   = 1'b0;

   bit          exp_ready [3];
   bit          exp_valid [3];
   bit          exp_err   [3];
   bit          exp_rchk  [3];
   logic [63:0] exp_rdata [3];

   logic [63:0] mm [int];

   int in_idx [7] = '{0, 1, 2, 3, 5, 100, 4095};
   logic [63:0] oor_addr [5] = '{64'h7FFF_FFF8, 64'h8000_8000, 64'h0,
                                 64'hFFFF_FFFF_FFFF_FFF8, 64'h1_8000_0000};

   function automatic int lat_of(int g);
      return (g == 0) ? 1 : ((g == 1) ? 2 : 5);
   endfunction

   function automatic bit in_rng(logic [63:0] a);
      return (a >= BASE) && (a < LIMIT);
   endfunction

   function automatic int key_of(int g, logic [63:0] a);
      return g * 4096 + int'((a - BASE) / 64'd8);
   endfunction

   task automatic chk(string nm, int g, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, g, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         for (int g = 0; g < 3; g++) begin
            chk("ready", g, 64'(ready[g]), 64'(exp_ready[g]));
            chk("rdata_valid", g, 64'(valid[g]), 64'(exp_valid[g]));
            chk("err", g, 64'(err[g]), 64'(exp_err[g]));
            if (exp_valid[g] || exp_rchk[g]) chk("rdata", g, rdata[g], exp_rdata[g]);
         end
      end
   end

   function automatic logic [63:0] rand_addr();
      if ($urandom_range(0, 4) == 0) return oor_addr[$urandom_range(0, 4)];
      return BASE + 64'(in_idx[$urandom_range(0, 6)]) * 64'd8 + 64'($urandom_range(0, 7));
   endfunction

   task automatic set_idle_exp(int g);
      exp_ready[g] = 1'b1;
      exp_valid[g] = 1'b0;
      exp_err[g]   = 1'b0;
      exp_rchk[g]  = 1'b0;
   endtask

   // One request; fl_at = cycle offset after accept carrying flush (0 = none).
   // rst_at1 resets the instance in the first cycle after accept.
   task automatic xact(int g, bit r_en, logic [63:0] ra, bit w_en, logic [63:0] wa,
                       logic [63:0] wd, logic [7:0] wm, int fl_at, bit rst_at1,
                       output logic [63:0] got, output bit got_v);
      int          L;
      bit          rok, wok, e_err, flushed;
      logic [63:0] e_rd, nw;
      L       = lat_of(g);
      rok     = in_rng(ra);
      wok     = in_rng(wa);
      e_err   = (r_en && !rok) || (w_en && !wok);
      e_rd    = (r_en && rok) ? mm[key_of(g, ra)] : 64'h0;
      got     = 64'h0;
      got_v   = 1'b0;
      flushed = 1'b0;

      rwvalid[g] = 1'b1; ren[g] = r_en; raddr[g] = ra; wen[g] = w_en;
      waddr[g] = wa; wdata[g] = wd; wmask[g] = wm; flush[g] = 1'b0;
      set_idle_exp(g);
      @(posedge clk); #1;
      rwvalid[g] = 1'b0; ren[g] = $urandom_range(0, 1); wen[g] = $urandom_range(0, 1);
      raddr[g] = rand_addr(); waddr[g] = rand_addr();
      wdata[g] = {$urandom, $urandom}; wmask[g] = 8'($urandom);

      if (rst_at1) begin
         rst[g] = 1'b1;
         exp_ready[g] = 1'b0;
         @(posedge clk); #1;
         rst[g] = 1'b0;
         set_idle_exp(g);
         exp_rchk[g]  = 1'b1;
         exp_rdata[g] = 64'h0;
         @(posedge clk); #1;
         exp_rchk[g] = 1'b0;
         return;
      end

      for (int k = 1; k <= L; k++) begin
         flush[g] = (k == fl_at);
         if (k == fl_at) flushed = 1'b1;
         exp_ready[g] = 1'b0;
         exp_valid[g] = (k == L) && r_en && !flushed;
         exp_err[g]   = (k == L) && e_err;
         exp_rdata[g] = e_rd;
         @(negedge clk);
         if (k == L) begin
            got   = rdata[g];
            got_v = valid[g];
         end
         @(posedge clk); #1;
      end
      flush[g] = 1'b0;
      set_idle_exp(g);

      if (w_en && wok) begin
         nw = mm[key_of(g, wa)];
         for (int i = 0; i < 8; i++) if (wm[i]) nw[8*i +: 8] = wd[8*i +: 8];
         mm[key_of(g, wa)] = nw;
      end
   endtask

   task automatic wr(int g, logic [63:0] a, logic [63:0] d, logic [7:0] m, int fl_at);
      logic [63:0] got;
      bit          gv;
      xact(g, 1'b0, 64'h0, 1'b1, a, d, m, fl_at, 1'b0, got, gv);
   endtask

   task automatic rd(int g, logic [63:0] a, int fl_at, output logic [63:0] got, output bit gv);
      xact(g, 1'b1, a, 1'b0, 64'h0, 64'h0, 8'h00, fl_at, 1'b0, got, gv);
   endtask

   task automatic idle(int g, int n, bit blocked);
      for (int i = 0; i < n; i++) begin
         rwvalid[g] = blocked; flush[g] = blocked; ren[g] = 1'b1; wen[g] = 1'b1;
         raddr[g] = rand_addr(); waddr[g] = BASE; wdata[g] = 64'hDEAD_BEEF_DEAD_BEEF;
         wmask[g] = 8'hFF;
         set_idle_exp(g);
         @(posedge clk); #1;
      end
      rwvalid[g] = 1'b0; flush[g] = 1'b0; ren[g] = 1'b0; wen[g] = 1'b0;
   endtask

   task automatic t1(int g);
      logic [63:0] got;
      bit          gv;
      wr(g, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0);
      rd(g, 64'h8000_0010, 0, got, gv);
      chk("t1_valid", g, 64'(gv), 64'h1);
      chk("t1_rdata", g, got, 64'h1122_3344_5566_7788);
   endtask

   initial begin
      logic [63:0] got;
      bit          gv;
      for (int g = 0; g < 3; g++) begin
         rst[g] = 1'b1; rwvalid[g] = 1'b0; ren[g] = 1'b0; wen[g] = 1'b0; flush[g] = 1'b0;
         raddr[g] = '0; waddr[g] = '0; wdata[g] = '0; wmask[g] = '0;
         set_idle_exp(g);
         exp_rchk[g] = 1'b1; exp_rdata[g] = 64'h0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) rst[g] = 1'b0;
      run = 1'b1;
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) exp_rchk[g] = 1'b0;

      for (int g = 0; g < 3; g++)
         for (int i = 0; i < 7; i++)
            wr(g, BASE + 64'(in_idx[i]) * 64'd8, {$urandom, $urandom}, 8'hFF, 0);

      t1(1);
      wr(1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0);
      rd(1, 64'h8000_0010, 0, got, gv);
      chk("t2_partial", 1, got, 64'h1122_3344_FFFF_FFFF);

      rd(1, 64'h7FFF_FFF8, 0, got, gv);
      chk("t3_low_oor_rdata", 1, got, 64'h0);
      rd(1, 64'h8000_8000, 0, got, gv);
      chk("t3_high_oor_rdata", 1, got, 64'h0);
      wr(1, 64'h8000_0000, 64'h0BAD_0000_0000_0001, 8'hFF, 0);
      wr(1, 64'h8000_8000, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 0);
      wr(1, 64'h1_8000_0000, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 0);
      rd(1, 64'h8000_0000, 0, got, gv);
      chk("t3_no_alias", 1, got, 64'h0BAD_0000_0000_0001);
      wr(1, 64'h8000_0000, 64'h5555_5555_5555_5555, 8'h00, 0);
      rd(1, 64'h8000_0000, 0, got, gv);
      chk("mask00_no_change", 1, got, 64'h0BAD_0000_0000_0001);

      rd(1, 64'h8000_0010, 1, got, gv);
      chk("t4_flush_read", 1, 64'(gv), 64'h0);
      wr(1, 64'h8000_0028, 64'h0123_4567_89AB_CDEF, 8'hFF, 1);
      rd(1, 64'h8000_0028, 0, got, gv);
      chk("t4_flush_write", 1, got, 64'h0123_4567_89AB_CDEF);

      wr(1, 64'h8000_0018, 64'hAAAA_0000_AAAA_0000, 8'hFF, 0);
      xact(1, 1'b1, 64'h8000_0018, 1'b1, 64'h8000_0018, 64'hBBBB_1111_BBBB_1111, 8'hFF,
           0, 1'b0, got, gv);
      chk("t5_rbw_old", 1, got, 64'hAAAA_0000_AAAA_0000);
      rd(1, 64'h8000_0018, 0, got, gv);
      chk("t5_rbw_new", 1, got, 64'hBBBB_1111_BBBB_1111);
      idle(1, 2, 1'b1);

      wr(1, 64'h8000_0008, 64'h7777_6666_5555_4444, 8'hFF, 0);
      xact(1, 1'b0, 64'h0, 1'b1, 64'h8000_0008, 64'h9999_9999_9999_9999, 8'hFF,
           0, 1'b1, got, gv);
      rd(1, 64'h8000_0008, 0, got, gv);
      chk("t6_rst_drop", 1, got, 64'h7777_6666_5555_4444);

      t1(0);
      t1(2);
      wr(2, 64'h8000_0008, 64'h1357_9BDF_2468_ACE0, 8'hFF, 0);
      xact(2, 1'b0, 64'h0, 1'b1, 64'h8000_0008, 64'h0, 8'hFF, 0, 1'b1, got, gv);
      rd(2, 64'h8000_0008, 0, got, gv);
      chk("t6_rst_drop_l5", 2, got, 64'h1357_9BDF_2468_ACE0);

      for (int g = 0; g < 3; g++) begin
         for (int n = 0; n < 80; n++) begin
            bit          r_en, w_en;
            logic [63:0] ra, wa;
            logic [7:0]  wm;
            int          fl, sel;
            r_en = $urandom_range(0, 1);
            w_en = $urandom_range(0, 1);
            ra   = rand_addr();
            wa   = ($urandom_range(0, 2) == 0) ? ra : rand_addr();
            sel  = $urandom_range(0, 5);
            wm   = (sel == 0) ? 8'h00 : ((sel == 1) ? 8'hFF : 8'($urandom));
            fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat_of(g)) : 0;
            xact(g, r_en, ra, w_en, wa, {$urandom, $urandom}, wm, fl, 1'b0, got, gv);
            if ($urandom_range(0, 2) == 0) idle(g, $urandom_range(1, 2), $urandom_range(0, 1));
         end
      end

      @(posedge clk); #1;
      run = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
